// File: rtl/spi_axis_txn_seq.sv
// rtl/spi_axis_txn_seq.sv - write/skip/read transaction sequencer in front of a byte-stream SPI master
module spi_axis_txn_seq #(
    parameter int LEN_W        = 16,
    parameter int DRAIN_CYCLES = 8
) (
    input  logic             clk,
    input  logic             resn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_wr_len,
    input  logic [7:0]       cmd_rd_skip,
    input  logic [LEN_W-1:0] cmd_rd_len,
    input  logic             abort,
    input  logic [7:0]       tx_tdata,
    input  logic             tx_tvalid,
    output logic             tx_tready,
    output logic [7:0]       rx_tdata,
    output logic             rx_tvalid,
    input  logic             rx_tready,
    output logic             rx_tlast,
    output logic [7:0]       if_s_axis_tdata,
    output logic             if_s_axis_tvalid,
    input  logic             if_s_axis_tready,
    input  logic [7:0]       if_m_axis_tdata,
    input  logic             if_m_axis_tvalid,
    output logic             if_m_axis_tready,
    output logic             if_enable,
    input  logic             if_csn,
    output logic             busy,
    output logic             done,
    output logic [7:0]       drop_cnt
);
    localparam int RD_W   = LEN_W + 1;
    localparam int IDLE_W = $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;
    state_t state, state_nxt;

    logic [LEN_W-1:0]  wr_len;
    logic [LEN_W-1:0]  wr_cnt;
    logic [7:0]        rd_skip;
    logic [RD_W-1:0]   rd_need;
    logic [RD_W-1:0]   rd_total;
    logic [IDLE_W-1:0] idle_cnt;

    logic [RD_W-1:0] cmd_need;
    logic            cmd_hs;
    logic            in_skip;
    logic            m_rdy;
    logic            s_hs;
    logic            m_hs;
    logic            drop_hs;
    logic            rd_last;

    assign cmd_need = RD_W'(cmd_rd_len) + RD_W'(cmd_rd_skip);
    assign cmd_hs   = cmd_valid && (state == S_IDLE);
    assign in_skip  = rd_total < RD_W'(rd_skip);
    assign rd_last  = rd_total == rd_need - 1'b1;

    // Read-phase payload bytes are flow-controlled by the user; everything else is sunk freely.
    assign m_rdy = (state == S_READ && !in_skip) ? rx_tready
                 : (state == S_WRITE || state == S_READ || state == S_DRAIN);
    assign m_hs    = if_m_axis_tvalid && m_rdy;
    assign s_hs    = (state == S_WRITE) && tx_tvalid && if_s_axis_tready;
    assign drop_hs = m_hs && (state != S_READ || in_skip);

    assign if_m_axis_tready = m_rdy;
    assign if_s_axis_tdata  = tx_tdata;
    assign rx_tdata         = if_m_axis_tdata;

    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        cmd_ready        = 1'b0;
        busy             = 1'b1;
        done             = 1'b0;
        tx_tready        = 1'b0;
        if_s_axis_tvalid = 1'b0;
        rx_tvalid        = 1'b0;
        rx_tlast         = 1'b0;
        if_enable        = 1'b0;
        case (state)
            S_IDLE: begin
                busy      = 1'b0;
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (cmd_wr_len != '0)    state_nxt = S_WRITE;
                    else if (cmd_need != '0) state_nxt = S_READ;
                    else                     state_nxt = S_DRAIN;
                end
            end
            S_WRITE: begin
                if_s_axis_tvalid = tx_tvalid;
                tx_tready        = if_s_axis_tready;
                if (s_hs && wr_cnt == wr_len - 1'b1) begin
                    state_nxt = (rd_need != '0) ? S_READ : S_DRAIN;
                end
                if (abort) state_nxt = S_DRAIN;
            end
            S_READ: begin
                if_enable = rd_total < rd_need;
                rx_tvalid = !in_skip && if_m_axis_tvalid;
                rx_tlast  = rx_tvalid && rd_last;
                if (m_hs && rd_last) state_nxt = S_DRAIN;
                if (abort)           state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (if_csn && !m_hs && idle_cnt == IDLE_W'(DRAIN_CYCLES - 1)) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            wr_len   <= '0;
            wr_cnt   <= '0;
            rd_skip  <= '0;
            rd_need  <= '0;
            rd_total <= '0;
            drop_cnt <= '0;
            idle_cnt <= '0;
        end else begin
            if (cmd_hs) begin
                wr_len   <= cmd_wr_len;
                rd_skip  <= cmd_rd_skip;
                rd_need  <= cmd_need;
                wr_cnt   <= '0;
                rd_total <= '0;
                drop_cnt <= '0;
            end else begin
                if (s_hs)                   wr_cnt   <= wr_cnt + 1'b1;
                if (state == S_READ && m_hs) rd_total <= rd_total + 1'b1;
                if (drop_hs && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
            end
            // Idle streak only counts quiet cycles with the link deselected.
            if (state != S_DRAIN || m_hs || !if_csn) idle_cnt <= '0;
            else                                      idle_cnt <= idle_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_spi_axis_txn_seq.sv
// tb/tb_spi_axis_txn_seq.sv - scoreboard bench for spi_axis_txn_seq with a behavioural SPI link
module tb_spi_axis_txn_seq;
    localparam int LEN_W        = 16;
    localparam int DRAIN_CYCLES = 8;
    localparam int BYTE_CYC     = 4;

    logic             clk = 1'b0;
    logic             resn;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [LEN_W-1:0] cmd_wr_len;
    logic [7:0]       cmd_rd_skip;
    logic [LEN_W-1:0] cmd_rd_len;
    logic             abort;
    logic [7:0]       tx_tdata;
    logic             tx_tvalid;
    logic             tx_tready;
    logic [7:0]       rx_tdata;
    logic             rx_tvalid;
    logic             rx_tready;
    logic             rx_tlast;
    logic [7:0]       if_s_axis_tdata;
    logic             if_s_axis_tvalid;
    logic             if_s_axis_tready;
    logic [7:0]       if_m_axis_tdata;
    logic             if_m_axis_tvalid;
    logic             if_m_axis_tready;
    logic             if_enable;
    logic             if_csn;
    logic             busy;
    logic             done;
    logic [7:0]       drop_cnt;

    always #5 clk = ~clk;

    spi_axis_txn_seq #(.LEN_W(LEN_W), .DRAIN_CYCLES(DRAIN_CYCLES)) dut (
        .clk(clk), .resn(resn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_wr_len(cmd_wr_len), .cmd_rd_skip(cmd_rd_skip), .cmd_rd_len(cmd_rd_len),
        .abort(abort),
        .tx_tdata(tx_tdata), .tx_tvalid(tx_tvalid), .tx_tready(tx_tready),
        .rx_tdata(rx_tdata), .rx_tvalid(rx_tvalid), .rx_tready(rx_tready), .rx_tlast(rx_tlast),
        .if_s_axis_tdata(if_s_axis_tdata), .if_s_axis_tvalid(if_s_axis_tvalid),
        .if_s_axis_tready(if_s_axis_tready),
        .if_m_axis_tdata(if_m_axis_tdata), .if_m_axis_tvalid(if_m_axis_tvalid),
        .if_m_axis_tready(if_m_axis_tready),
        .if_enable(if_enable), .if_csn(if_csn),
        .busy(busy), .done(done), .drop_cnt(drop_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] tx_q[$];
    logic [7:0] dev_q[$];
    logic [7:0] m_q[$];
    logic [7:0] exp_wr_q[$];
    logic [8:0] exp_rx_q[$];
    logic [7:0] exp_done_q[$];

    int         byte_timer;
    logic [7:0] byte_val;
    int         cyc;
    int         rx_mode;
    int         fwd_cnt;
    int         acc_cyc;
    int         done_cyc;
    bit         chk_mirror;
    bit         chk_en_fall;
    bit         got_done;
    bit         s_hs_q, m_hs_q, tx_hs_q, en_q, acc_q;
    logic [7:0] s_data_q;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic drive_outputs();
        if_s_axis_tready = (byte_timer == 0);
        if_m_axis_tvalid = (m_q.size() > 0);
        if_m_axis_tdata  = (m_q.size() > 0) ? m_q[0] : 8'h00;
        if_csn           = (byte_timer == 0) && (m_q.size() == 0);
        tx_tvalid        = (tx_q.size() > 0);
        tx_tdata         = (tx_q.size() > 0) ? tx_q[0] : 8'h00;
        rx_tready        = (rx_mode == 0) ? 1'b1 : (cyc % 3 == 0);
    endtask

    // Mid-cycle: record handshakes and score DUT outputs.
    task automatic half_sample();
        logic [8:0] e;
        @(negedge clk);
        s_hs_q   = if_s_axis_tvalid && if_s_axis_tready;
        s_data_q = if_s_axis_tdata;
        m_hs_q   = if_m_axis_tvalid && if_m_axis_tready;
        tx_hs_q  = tx_tvalid && tx_tready;
        en_q     = if_enable;
        acc_q    = cmd_valid && cmd_ready;
        if (acc_q) acc_cyc = cyc;
        if (chk_en_fall) begin
            check_eq("en_fall", 32'(if_enable), 32'(0));
            chk_en_fall = 1'b0;
        end
        if (chk_mirror && rx_tvalid) check_eq("mirror", 32'(if_m_axis_tready), 32'(rx_tready));
        if (s_hs_q) begin
            check_eq("wr_avail", 32'(exp_wr_q.size() > 0), 32'(1));
            if (exp_wr_q.size() > 0) check_eq("wr_data", 32'(s_data_q), 32'(exp_wr_q.pop_front()));
        end
        if (rx_tvalid && rx_tready) begin
            fwd_cnt++;
            check_eq("rx_avail", 32'(exp_rx_q.size() > 0), 32'(1));
            if (exp_rx_q.size() > 0) begin
                e = exp_rx_q.pop_front();
                check_eq("rx_data", 32'(rx_tdata), 32'(e[7:0]));
                check_eq("rx_last", 32'(rx_tlast), 32'(e[8]));
            end
            if (rx_tlast) chk_en_fall = 1'b1;
        end
        if (done) begin
            got_done = 1'b1;
            done_cyc = cyc;
            check_eq("done_avail", 32'(exp_done_q.size() > 0), 32'(1));
            if (exp_done_q.size() > 0) check_eq("drop_cnt", 32'(drop_cnt), 32'(exp_done_q.pop_front()));
        end
    endtask

    // Just after the edge: advance the SPI link model and drive new inputs.
    task automatic half_drive();
        @(posedge clk);
        #1;
        if (acc_q) cmd_valid = 1'b0;
        if (m_hs_q) void'(m_q.pop_front());
        if (tx_hs_q) void'(tx_q.pop_front());
        if (byte_timer > 0) begin
            byte_timer--;
            if (byte_timer == 0) m_q.push_back(byte_val);
        end else if (s_hs_q) begin
            byte_timer = BYTE_CYC;
            byte_val   = s_data_q ^ 8'hFF;
        end else if (en_q && !m_hs_q && m_q.size() == 0) begin
            byte_timer = BYTE_CYC;
            if (dev_q.size() > 0) byte_val = dev_q.pop_front();
            else                  byte_val = 8'hFF;
        end
        cyc++;
        drive_outputs();
    endtask

    task automatic step();
        half_sample();
        half_drive();
    endtask

    task automatic issue(input int wr, input int skip, input int rd, input int exp_drop);
        cmd_wr_len  = LEN_W'(wr);
        cmd_rd_skip = 8'(skip);
        cmd_rd_len  = LEN_W'(rd);
        cmd_valid   = 1'b1;
        exp_done_q.push_back(8'(exp_drop));
        fwd_cnt  = 0;
        got_done = 1'b0;
        for (int i = 0; i < 20 && cmd_valid; i++) step();
        check_eq("cmd_acc", 32'(cmd_valid), 32'(0));
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && !got_done; i++) step();
        check_eq("done_seen", 32'(got_done), 32'(1));
        half_sample();
        check_eq("rdy_after", 32'(cmd_ready), 32'(1));
        check_eq("idle_after", 32'(busy), 32'(0));
        half_drive();
    endtask

    task automatic push_rx(input logic [7:0] d, input logic last);
        exp_rx_q.push_back({last, d});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resn = 1'b0; cmd_valid = 1'b0; cmd_wr_len = '0; cmd_rd_skip = '0; cmd_rd_len = '0;
        abort = 1'b0; byte_timer = 0; byte_val = '0; cyc = 0; rx_mode = 0; fwd_cnt = 0;
        acc_cyc = 0; done_cyc = 0; chk_mirror = 1'b0; chk_en_fall = 1'b0; got_done = 1'b0;
        drive_outputs();
        step();
        half_sample();
        check_eq("rst_cmd_ready", 32'(cmd_ready), 32'(1));
        check_eq("rst_busy", 32'(busy), 32'(0));
        check_eq("rst_done", 32'(done), 32'(0));
        check_eq("rst_enable", 32'(if_enable), 32'(0));
        check_eq("rst_drop", 32'(drop_cnt), 32'(0));
        check_eq("rst_rx_tvalid", 32'(rx_tvalid), 32'(0));
        check_eq("rst_s_tvalid", 32'(if_s_axis_tvalid), 32'(0));
        check_eq("rst_tx_tready", 32'(tx_tready), 32'(0));
        half_drive();
        resn = 1'b1;
        step();

        // Write only: three bytes out, three echoes discarded.
        tx_q = '{8'hA5, 8'h5A, 8'hFF};
        exp_wr_q = '{8'hA5, 8'h5A, 8'hFF};
        issue(3, 0, 0, 3);
        wait_done(2000);

        // Write opcode, skip echo plus one dummy, read three bytes.
        tx_q.push_back(8'h9F);
        exp_wr_q.push_back(8'h9F);
        dev_q = '{8'h00, 8'h11, 8'h22, 8'h33};
        push_rx(8'h11, 1'b0); push_rx(8'h22, 1'b0); push_rx(8'h33, 1'b1);
        issue(1, 2, 3, 2);
        wait_done(2000);

        // Read with user backpressure.
        rx_mode = 1;
        chk_mirror = 1'b1;
        dev_q = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
        push_rx(8'hC1, 1'b0); push_rx(8'hC2, 1'b0); push_rx(8'hC3, 1'b0); push_rx(8'hC4, 1'b1);
        issue(0, 0, 4, 0);
        wait_done(2000);
        check_eq("bp_count", 32'(fwd_cnt), 32'(4));
        rx_mode = 0;
        chk_mirror = 1'b0;

        // Zero-length: DRAIN_CYCLES quiet cycles, then done.
        issue(0, 0, 0, 0);
        half_sample();
        check_eq("zl_busy", 32'(busy), 32'(1));
        half_drive();
        wait_done(200);
        check_eq("zl_latency", 32'(done_cyc - acc_cyc), 32'(DRAIN_CYCLES + 1));

        // Abort a long read after 10 bytes; the one byte already clocked is drained.
        for (int i = 0; i < 100; i++) begin
            dev_q.push_back(8'(i * 3 + 1));
            push_rx(8'(i * 3 + 1), i == 99);
        end
        issue(0, 0, 100, 1);
        for (int i = 0; i < 3000 && fwd_cnt < 10; i++) step();
        check_eq("abort_fwd", 32'(fwd_cnt), 32'(10));
        abort = 1'b1;
        half_sample();
        half_drive();
        abort = 1'b0;
        half_sample();
        check_eq("abort_enable", 32'(if_enable), 32'(0));
        check_eq("abort_rx_tvalid", 32'(rx_tvalid), 32'(0));
        half_drive();
        check_eq("abort_left", 32'(exp_rx_q.size()), 32'(90));
        exp_rx_q.delete();
        dev_q.delete();
        wait_done(2000);

        // Asynchronous reset in the middle of a read.
        for (int i = 0; i < 20; i++) begin
            dev_q.push_back(8'(8'h40 + i));
            push_rx(8'(8'h40 + i), i == 19);
        end
        issue(0, 0, 20, 0);
        for (int i = 0; i < 3000 && fwd_cnt < 3; i++) step();
        check_eq("rst_mid_fwd", 32'(fwd_cnt), 32'(3));
        resn = 1'b0;
        #2;
        check_eq("rst_mid_enable", 32'(if_enable), 32'(0));
        check_eq("rst_mid_busy", 32'(busy), 32'(0));
        check_eq("rst_mid_ready", 32'(cmd_ready), 32'(1));
        check_eq("rst_mid_rxv", 32'(rx_tvalid), 32'(0));
        byte_timer = 0;
        m_q.delete(); dev_q.delete(); tx_q.delete();
        exp_rx_q.delete(); exp_done_q.delete(); exp_wr_q.delete();
        chk_en_fall = 1'b0;
        drive_outputs();
        step();
        resn = 1'b1;
        step();
        half_sample();
        check_eq("rst_mid_drop", 32'(drop_cnt), 32'(0));
        half_drive();

        // Fresh command after reset.
        tx_q.push_back(8'h3C);
        exp_wr_q.push_back(8'h3C);
        dev_q = '{8'h77, 8'h88};
        push_rx(8'h77, 1'b0); push_rx(8'h88, 1'b1);
        issue(1, 1, 2, 1);
        wait_done(2000);

        check_eq("rx_left", 32'(exp_rx_q.size()), 32'(0));
        check_eq("wr_left", 32'(exp_wr_q.size()), 32'(0));
        check_eq("done_left", 32'(exp_done_q.size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
